// File: rtl/med_pkg.sv
// Shared definitions for the 3-tap streaming median filter.
// Holds the default sample width and the controller state encoding.
package med_pkg;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;
endpackage

// File: rtl/med3_core.sv
// Combinational unsigned middle-of-three selector.
// Ties fall out naturally: any duplicated value is returned.
module med3_core #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   output logic [DW-1:0] m
);
   logic [DW-1:0] lo_ab;
   logic [DW-1:0] hi_ab;
   logic [DW-1:0] lo_hc;

   // median = max(min(a,b), min(max(a,b), c))
   assign lo_ab = (a < b) ? a : b;
   assign hi_ab = (a < b) ? b : a;
   assign lo_hc = (hi_ab < c) ? hi_ab : c;
   assign m     = (lo_ab > lo_hc) ? lo_ab : lo_hc;
endmodule

// File: rtl/median_stream_ctrl.sv
// Streaming 3-tap median filter with edge replication per line.
// Two-sample window, one output register, valid/ready on both sides.
module median_stream_ctrl
   import med_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy
);
   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] w_prev;
   logic [DW-1:0] w_cur;
   logic [DW-1:0] ma;
   logic [DW-1:0] mb;
   logic [DW-1:0] mc;
   logic [DW-1:0] med;
   logic          out_free;
   logic          acc;
   logic          load;
   logic          load_last;
   logic          shift;
   logic          cap_first;

   assign out_free = ~out_valid | out_ready;
   assign in_ready = (state != FLUSH) & out_free;
   assign acc      = in_valid & in_ready;
   assign busy     = (state != IDLE) | out_valid;

   med3_core #(.DW(DW)) u_med (
      .a(ma),
      .b(mb),
      .c(mc),
      .m(med)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The median operands select the window taps; in IDLE all three are the
   // incoming sample so a one-sample line passes straight through.
   always_comb begin
      state_nxt = state;
      ma        = in_data;
      mb        = in_data;
      mc        = in_data;
      load      = 1'b0;
      load_last = 1'b0;
      shift     = 1'b0;
      cap_first = 1'b0;
      case (state)
         IDLE: begin
            if (acc) begin
               if (in_last) begin
                  load      = 1'b1;
                  load_last = 1'b1;
               end else begin
                  cap_first = 1'b1;
                  state_nxt = FILL;
               end
            end
         end
         FILL: begin
            ma = w_cur;
            mb = w_cur;
            if (acc) begin
               load      = 1'b1;
               shift     = 1'b1;
               state_nxt = in_last ? FLUSH : RUN;
            end
         end
         RUN: begin
            ma = w_prev;
            mb = w_cur;
            if (acc) begin
               load      = 1'b1;
               shift     = 1'b1;
               state_nxt = in_last ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            ma = w_prev;
            mb = w_cur;
            mc = w_cur;
            if (out_free) begin
               load      = 1'b1;
               load_last = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_prev <= '0;
         w_cur  <= '0;
      end else begin
         if (shift) begin
            w_prev <= w_cur;
         end
         if (shift || cap_first) begin
            w_cur <= in_data;
         end
      end
   end

   // Reload and handshake in the same cycle keeps out_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= med;
         out_last  <= load_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_median_stream_ctrl.sv
// Bench for median_stream_ctrl: directed lines plus randomly throttled lines,
// checked against a line-level median reference kept in the bench.
module tb_median_stream_ctrl;
   localparam int DW = 8;
   typedef int iq_t[$];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;

   int  checks = 0;
   int  failures = 0;
   int  exp_q[$];
   int  hs_cyc[$];
   int  cyc = 0;
   bit  rnd_mode = 1'b0;
   int  stall = 0;

   median_stream_ctrl #(.DW(DW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic int med3m(input int a, input int b, input int c);
      int mx;
      int mn;
      mx = a;
      mn = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      if (b < mn) mn = b;
      if (c < mn) mn = c;
      return a + b + c - mx - mn;
   endfunction

   function automatic iq_t ref_line(input iq_t x);
      iq_t y;
      int  n;
      int  a;
      int  c;
      n = x.size();
      for (int i = 0; i < n; i++) begin
         a = (i == 0) ? x[0] : x[i-1];
         c = (i == n-1) ? x[n-1] : x[i+1];
         y.push_back(med3m(a, x[i], c));
      end
      return y;
   endfunction

   task automatic push_model(input iq_t x);
      iq_t y;
      y = ref_line(x);
      for (int i = 0; i < y.size(); i++)
         exp_q.push_back(y[i] | ((i == y.size()-1) ? 256 : 0));
   endtask

   task automatic pin(input string nm, input iq_t x, input iq_t req);
      iq_t y;
      y = ref_line(x);
      chk({nm, "_len"}, y.size(), req.size());
      for (int i = 0; i < req.size() && i < y.size(); i++)
         chk(nm, y[i], req[i]);
   endtask

   // Output-side monitor: samples mid-cycle, where the next edge's handshake is settled.
   initial begin
      bit            prev_stall;
      logic [DW-1:0] pd;
      logic          pl;
      int            e;
      prev_stall = 1'b0;
      pd = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, pd);
               chk("hold_last", out_last, pl);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid) chk("busy_with_output", busy, 1);
            if (out_valid && out_ready) begin
               hs_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out actual=%0d required=none t=%0t", out_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e & 255);
                  chk("out_last", out_last, e >> 8);
               end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall > 0) begin
         out_ready = 1'b0;
         stall--;
      end else begin
         out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   task automatic send(input int d, input bit l);
      bit ok;
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d[DW-1:0];
      in_last  = l;
      for (int n = 0; n < 200 && !done; n++) begin
         #1;
         ok = in_ready;
         tick();
         done = ok;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept required=accept data=%0d", d);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
      repeat (2) tick();
   endtask

   initial begin
      iq_t x;
      int  base;
      int  len;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // literal pins on the reference model
      pin("pin_5tap", '{10, 50, 20, 80, 30}, '{10, 20, 50, 30, 30});
      pin("pin_one", '{127}, '{127});
      pin("pin_two", '{1, 9}, '{1, 9});
      pin("pin_ties", '{5, 5, 200}, '{5, 5, 200});

      // five-sample line, full throughput downstream
      exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(50);
      exp_q.push_back(30); exp_q.push_back(30 | 256);
      send(10, 0); send(50, 0); send(20, 0); send(80, 0); send(30, 1);
      drain();

      // single-sample line
      exp_q.push_back(8'h7F | 256);
      send(8'h7F, 1);
      drain();
      chk("single_idle_busy", busy, 0);
      chk("single_in_ready", in_ready, 1);

      // downstream stall right after the first output
      exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(200 | 256);
      send(5, 0);
      send(5, 0);
      out_ready = 1'b0;
      stall = 2;
      #1;
      chk("stall_out_data", out_data, 5);
      chk("stall_in_ready_dir", in_ready, 0);
      send(200, 1);
      drain();

      // back-to-back lines: one bubble per line end
      base = hs_cyc.size();
      exp_q.push_back(1); exp_q.push_back(9 | 256);
      exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4 | 256);
      send(1, 0); send(9, 1); send(4, 0); send(4, 0); send(4, 1);
      drain();
      chk("b2b_count", hs_cyc.size() - base, 5);
      if (hs_cyc.size() >= base + 5)
         chk("b2b_span", hs_cyc[base+4] - hs_cyc[base], 5);

      // reset in the middle of a line
      exp_q.push_back(8'hFF); exp_q.push_back(8'h80);
      send(8'hFF, 0); send(8'h00, 0); send(8'h80, 0);
      repeat (3) tick();
      chk("pre_rst_consumed", exp_q.size(), 0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_busy", busy, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      exp_q.push_back(3 | 256);
      send(3, 1);
      drain();

      // randomly throttled lines against the reference model
      rnd_mode = 1'b1;
      for (int l = 0; l < 1000; l++) begin
         x.delete();
         len = $urandom_range(1, 16);
         for (int i = 0; i < len; i++) x.push_back($urandom_range(0, 255));
         push_model(x);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(x[i], i == len - 1);
         end
      end
      rnd_mode = 1'b0;
      drain();
      chk("final_drained", exp_q.size(), 0);
      chk("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/median_stream_ctrl.md
MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

Interface
REQ-001 Parameter: DW, 8, sample width in bits (unsigned).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream sample valid.
REQ-005 Port: in_ready  output  1  block accepts sample this cycle.
REQ-006 Port: in_data  input  DW  upstream sample.
REQ-007 Port: in_last  input  1  sample is final sample of current line.
REQ-008 Port: out_valid  output  1  filtered sample valid.
REQ-009 Port: out_ready  input  1  downstream accepts sample.
REQ-010 Port: out_data  output  DW  3-tap median result.
REQ-011 Port: out_last  output  1  result is final sample of line.
REQ-012 Port: busy  output  1  high whenever state is not IDLE or out_valid is high.

Function
REQ-013 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-014 Line of N input samples x[0..N-1] SHALL yield exactly N outputs y[0..N-1], in order, with edge replication: y[0]=med(x0,x0,x1), y[i]=med(x[i-1],x[i],x[i+1]), y[N-1]=med(x[N-2],x[N-1],x[N-1]); N=1 gives y[0]=x0.
REQ-015 med() SHALL be the unsigned middle value of three; ties return the tied value.
REQ-016 States: IDLE (no sample held), FILL (one sample held), RUN (two samples held), FLUSH (line ended, final output pending).
REQ-017 IDLE: accept without in_last -> store x0, go FILL, no output; accept with in_last -> load y=x0, out_last=1, stay IDLE.
REQ-018 FILL: accept x1 -> load med(x0,x0,x1), shift window; go FLUSH if in_last, else RUN.
REQ-019 RUN: accept x -> load med(w_prev,w_cur,x), shift window; go FLUSH if in_last, else stay RUN.
REQ-020 FLUSH: when output register free, load med(w_prev,w_cur,w_cur) with out_last=1, go IDLE.
REQ-021 Output register free = ~out_valid | out_ready.
REQ-022 in_ready = (state != FLUSH) & output-register-free; combinational, no dependence on in_valid.
REQ-023 Latency: result from accepting handshake SHALL appear on out_data/out_valid the following cycle.
REQ-024 out_data, out_last, out_valid SHALL hold stable while out_valid & ~out_ready.
REQ-025 Simultaneous output handshake and new load in same cycle: register reloads, out_valid stays 1 (full throughput, one sample per cycle).
REQ-026 No load cycle with output handshake: out_valid deasserts next cycle.
REQ-027 out_last SHALL be 0 on every non-final output.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, out_last=0, window registers=0.
REQ-029 rst mid-line SHALL discard held samples and pending output; no partial line is emitted after release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Shared package med_pkg SHALL hold DW default and the state enumeration (IDLE, FILL, RUN, FLUSH).
REQ-032 Combinational median SHALL be one sub-module med3_core (inputs a,b,c of DW; output m), instantiated once, shared by all states.
REQ-033 Controller holds window registers, state register, output register; no other storage.

Verification
REQ-034 Line 10,50,20,80,30(last), out_ready=1 -> outputs 10,20,50,30,30; out_last only on 5th.
REQ-035 Single sample 0x7F with in_last in IDLE -> one output 0x7F, out_last=1, state IDLE.
REQ-036 Line 5,5,200(last) with out_ready low 3 cycles after first output -> out_data holds 5, in_ready=0 while stalled; outputs 5,5,200.
REQ-037 Back-to-back lines 1,9(last) then 4,4,4(last), continuous valid/ready -> outputs 1,9 then 4,4,4; no bubble except FLUSH cycle per line.
REQ-038 Line 0xFF,0x00,0x80 (not last), rst pulse, then line 3(last) -> outputs before rst only; after rst single output 3 with out_last=1.
REQ-039 Random valid/ready throttling, 1000 random lines of length 1..16 -> output stream equal to REQ-014 reference model.
